// File: rtl/apb_master_bridge_if.sv
// Command/response handshake and APB bus bundle for apb_master_bridge.
// The bridge side uses the master modport. The host and slave environment use the slave modport.
interface apb_master_bridge_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_rsp_timeout;
  logic [AW-1:0] o_PADDR;
  logic [DW-1:0] o_PWDATA;
  logic          o_PWRITE;
  logic          o_PSEL;
  logic          o_PENABLE;
  logic [DW-1:0] i_PRDATA;
  logic          i_PREADY;
  logic          i_PSLVERR;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
           i_PRDATA, i_PREADY, i_PSLVERR,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
           o_PADDR, o_PWDATA, o_PWRITE, o_PSEL, o_PENABLE
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
           i_PRDATA, i_PREADY, i_PSLVERR,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
           o_PADDR, o_PWDATA, o_PWRITE, o_PSEL, o_PENABLE
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one valid/ready command becomes one SETUP+ACCESS transfer.
// It returns read data, slave error and timeout status on the response channel.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  apb_master_bridge_if.master  bus
);
  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          timeout;
  } rsp_t;

  state_t        state;
  req_t          req_q;
  rsp_t          rsp_q;
  logic [CW-1:0] cnt;
  logic          cmd_ready, rsp_valid, psel, penable;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      req_q     <= '0;
      rsp_q     <= '0;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.i_cmd_valid) begin
            req_q     <= '{write: bus.i_cmd_write, addr: bus.i_cmd_addr, wdata: bus.i_cmd_wdata};
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY is checked first so a ready on the last allowed cycle is not aborted.
          if (bus.i_PREADY) begin
            rsp_q     <= '{rdata: req_q.write ? '0 : bus.i_PRDATA, err: bus.i_PSLVERR, timeout: 1'b0};
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (TIMEOUT_CYCLES > 0 && cnt == CNT_LAST) begin
            rsp_q     <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_rsp_valid   = rsp_valid;
  assign bus.o_rsp_rdata   = rsp_q.rdata;
  assign bus.o_rsp_err     = rsp_q.err;
  assign bus.o_rsp_timeout = rsp_q.timeout;
  assign bus.o_PADDR       = req_q.addr;
  assign bus.o_PWDATA      = req_q.wdata;
  assign bus.o_PWRITE      = req_q.write;
  assign bus.o_PSEL        = psel;
  assign bus.o_PENABLE     = penable;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge. A transaction-level plan predicts every output cycle by cycle.
// A negedge compare process checks the DUT against that plan, and directed pins fix key values.
module tb_apb_master_bridge;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 4;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  apb_master_bridge_if #(.AW(AW), .DW(DW)) ifc ();

  apb_master_bridge #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(ifc)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // model: last latched request, last response, expected control outputs this cycle
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_err, m_to;
  logic          e_cmd_ready, e_rsp_valid, e_psel, e_pen, e_rst_state;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      check("cmd_ready", 64'(ifc.o_cmd_ready), 64'(e_cmd_ready));
      check("rsp_valid", 64'(ifc.o_rsp_valid), 64'(e_rsp_valid));
      check("psel",      64'(ifc.o_PSEL),      64'(e_psel));
      check("penable",   64'(ifc.o_PENABLE),   64'(e_pen));
      check("paddr",     64'(ifc.o_PADDR),     64'(m_addr));
      check("pwdata",    64'(ifc.o_PWDATA),    64'(m_wdata));
      check("pwrite",    64'(ifc.o_PWRITE),    64'(m_write));
      if (e_rsp_valid || e_rst_state) begin
        check("rsp_rdata",   64'(ifc.o_rsp_rdata),   64'(m_rdata));
        check("rsp_err",     64'(ifc.o_rsp_err),     64'(m_err));
        check("rsp_timeout", 64'(ifc.o_rsp_timeout), 64'(m_to));
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Inputs the bridge must ignore in the current cycle get random values.
  task automatic noise();
    ifc.i_cmd_write = 1'($urandom);
    ifc.i_cmd_addr  = AW'($urandom);
    ifc.i_cmd_wdata = $urandom;
    ifc.i_rsp_ready = 1'($urandom);
    ifc.i_PRDATA    = $urandom;
    ifc.i_PREADY    = 1'($urandom);
    ifc.i_PSLVERR   = 1'($urandom);
  endtask

  task automatic exp_idle();
    e_cmd_ready = 1'b1; e_rsp_valid = 1'b0; e_psel = 1'b0; e_pen = 1'b0; e_rst_state = 1'b0;
  endtask

  task automatic exp_reset();
    exp_idle();
    e_rst_state = 1'b1;
    m_write = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
  endtask

  task automatic reset_cycles(input int n);
    HRESET = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      noise();
      ifc.i_cmd_valid = 1'b0;
      exp_reset();
      chk_en = 1'b1;
    end
    HRESET = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      noise();
      ifc.i_cmd_valid = 1'b0;
      exp_idle();
    end
  endtask

  // w = wait states before PREADY (w >= TO means the slave never answers).
  // hold = cycles with rsp_ready low; rst_j = ACCESS cycle carrying HRESET (-1 = none).
  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int w, input bit e, input logic [DW-1:0] rd,
                         input int hold, input int rst_j, output int lat);
    int  k, nacc;
    bit  tmo;
    lat = 0;
    k = 0;
    step();
    noise();
    ifc.i_cmd_valid = 1'b1;
    ifc.i_cmd_write = wr; ifc.i_cmd_addr = a; ifc.i_cmd_wdata = wd;
    exp_idle();
    // SETUP
    step(); k++;
    noise();
    ifc.i_cmd_valid = 1'($urandom);
    m_write = wr; m_addr = a; m_wdata = wd;
    e_cmd_ready = 1'b0; e_psel = 1'b1; e_pen = 1'b0; e_rsp_valid = 1'b0;
    nacc = (w < TO) ? w + 1 : TO;
    for (int j = 0; j < nacc; j++) begin
      step(); k++;
      if (ifc.o_rsp_valid && lat == 0) lat = k;
      noise();
      ifc.i_cmd_valid = 1'($urandom);
      ifc.i_PREADY = (j == w);
      if (j == w) begin
        ifc.i_PRDATA = rd;
        ifc.i_PSLVERR = e;
      end
      e_pen = 1'b1;
      if (j == rst_j) begin
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        noise();
        ifc.i_cmd_valid = 1'b0;
        exp_reset();
        return;
      end
    end
    tmo = (w >= TO);
    m_to = tmo;
    m_err = tmo | e;
    m_rdata = (tmo || wr) ? '0 : rd;
    for (int h = 0; h <= hold; h++) begin
      step(); k++;
      if (ifc.o_rsp_valid && lat == 0) lat = k;
      noise();
      ifc.i_cmd_valid = 1'($urandom);
      ifc.i_rsp_ready = (h == hold);
      e_rsp_valid = 1'b1; e_cmd_ready = 1'b0; e_psel = 1'b0; e_pen = 1'b0;
    end
  endtask

  initial begin
    int lat;
    logic [DW-1:0] hold_rdata;
    ifc.i_cmd_valid = 1'b0;
    noise();
    reset_cycles(2);
    check("rst_cmd_ready", 64'(ifc.o_cmd_ready), 64'd1);
    check("rst_psel",      64'(ifc.o_PSEL),      64'd0);

    // 1: zero-wait write
    run_txn(1'b1, 12'h004, 32'h0000_0007, 0, 1'b0, 32'hDEAD_BEEF, 0, -1, lat);
    check("t1_latency", 64'(lat), 64'd3);
    check("t1_pwdata",  64'(ifc.o_PWDATA), 64'h7);
    check("t1_rdata",   64'(ifc.o_rsp_rdata), 64'd0);
    check("t1_err",     64'(ifc.o_rsp_err), 64'd0);

    // 2: read with three wait states
    run_txn(1'b0, 12'h000, 32'h1234_5678, 3, 1'b0, 32'h8000_002A, 0, -1, lat);
    check("t2_latency", 64'(lat), 64'd6);
    check("t2_rdata",   64'(ifc.o_rsp_rdata), 64'h8000_002A);
    check("t2_timeout", 64'(ifc.o_rsp_timeout), 64'd0);

    // 3: slave error on a read
    run_txn(1'b0, 12'h010, 32'h0, 1, 1'b1, 32'h5555_AAAA, 0, -1, lat);
    check("t3_err",     64'(ifc.o_rsp_err), 64'd1);
    check("t3_timeout", 64'(ifc.o_rsp_timeout), 64'd0);

    // 4: stuck slave aborts after TO access cycles
    run_txn(1'b0, 12'h020, 32'h0, 99, 1'b0, 32'hFFFF_FFFF, 0, -1, lat);
    check("t4_latency", 64'(lat), 64'd6);
    check("t4_err",     64'(ifc.o_rsp_err), 64'd1);
    check("t4_timeout", 64'(ifc.o_rsp_timeout), 64'd1);
    check("t4_rdata",   64'(ifc.o_rsp_rdata), 64'd0);

    // 4b: PREADY on the final allowed cycle wins over the timeout
    run_txn(1'b0, 12'h024, 32'h0, TO - 1, 1'b0, 32'h0BAD_F00D, 0, -1, lat);
    check("t4b_timeout", 64'(ifc.o_rsp_timeout), 64'd0);
    check("t4b_rdata",   64'(ifc.o_rsp_rdata), 64'h0BAD_F00D);

    // 5: response held for 5 cycles, then the next command goes straight through
    run_txn(1'b0, 12'h030, 32'h0, 0, 1'b0, 32'hC0FF_EE00, 5, -1, lat);
    hold_rdata = ifc.o_rsp_rdata;
    check("t5_rdata", 64'(hold_rdata), 64'hC0FF_EE00);
    run_txn(1'b1, 12'h034, 32'hA5A5_A5A5, 0, 1'b0, 32'h0, 0, -1, lat);
    check("t5_next_latency", 64'(lat), 64'd3);

    // 6: reset during ACCESS
    run_txn(1'b0, 12'h040, 32'h0, 2, 1'b0, 32'h1111_2222, 0, 1, lat);
    check("t6_psel",      64'(ifc.o_PSEL), 64'd0);
    check("t6_penable",   64'(ifc.o_PENABLE), 64'd0);
    check("t6_rsp_valid", 64'(ifc.o_rsp_valid), 64'd0);
    check("t6_cmd_ready", 64'(ifc.o_cmd_ready), 64'd1);

    // random traffic, including back-to-back transfers and occasional resets
    for (int n = 0; n < 200; n++) begin
      run_txn(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, TO + 2),
              1'($urandom), $urandom, $urandom_range(0, 3),
              ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5) : -1, lat);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
